// File: rtl/kernel_fm_load_if.sv
// Command, stream, RAM write and completion signals of the conv-engine loader.
// The slave modport is the loader; the master modport is whoever drives commands and stream words.
interface kernel_fm_load_if #(
    parameter int unsigned DATA_WIDTH    = 16,
    parameter int unsigned FM_ADDR_WIDTH = 19,
    parameter int unsigned W_ADDR_WIDTH  = 13,
    parameter int unsigned ID_WIDTH      = 4,
    parameter int unsigned SW            = 1
);
    logic                     cmd_valid;
    logic                     cmd_ready;
    logic [1:0]               cmd_op;
    logic [SW-1:0]            cmd_slot;
    logic [ID_WIDTH-1:0]      cmd_id;
    logic [FM_ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0]    cmd_data;

    logic                     src_valid;
    logic                     src_ready;
    logic [DATA_WIDTH-1:0]    src_data;

    logic                     fm_we;
    logic [FM_ADDR_WIDTH-1:0] fm_addr;
    logic [DATA_WIDTH-1:0]    fm_data;
    logic                     w_we;
    logic [W_ADDR_WIDTH-1:0]  w_addr;
    logic [DATA_WIDTH-1:0]    w_data;
    logic                     b_we;
    logic [SW-1:0]            b_addr;
    logic [DATA_WIDTH-1:0]    b_data;

    logic                     done_valid;
    logic [1:0]               done_op;
    logic [ID_WIDTH-1:0]      done_id;
    logic                     busy;

    modport master (
        output cmd_valid, cmd_op, cmd_slot, cmd_id, cmd_addr, cmd_data,
        output src_valid, src_data,
        input  cmd_ready, src_ready,
        input  fm_we, fm_addr, fm_data, w_we, w_addr, w_data, b_we, b_addr, b_data,
        input  done_valid, done_op, done_id, busy
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_slot, cmd_id, cmd_addr, cmd_data,
        input  src_valid, src_data,
        output cmd_ready, src_ready,
        output fm_we, fm_addr, fm_data, w_we, w_addr, w_data, b_we, b_addr, b_data,
        output done_valid, done_op, done_id, busy
    );
endinterface

// File: rtl/kernel_fm_load_controller.sv
// Loader moving a word stream into the FM / weight / bias RAM write ports, one word per clock,
// driven by ID-tagged commands with duplicate-ID absorption and an echoed completion pulse.
module kernel_fm_load_controller #(
    parameter int unsigned DATA_WIDTH    = 16,
    parameter int unsigned FM_ADDR_WIDTH = 19,
    parameter int unsigned W_ADDR_WIDTH  = 13,
    parameter int unsigned KERNEL_SLOTS  = 2,
    parameter int unsigned KERNEL_SIZE   = 363,
    parameter int unsigned FM_INIT_WORDS = 154587,
    parameter int unsigned ID_WIDTH      = 4
) (
    input logic             clk,
    input logic             rst,
    kernel_fm_load_if.slave bus
);
    localparam int unsigned SW      = (KERNEL_SLOTS > 1) ? $clog2(KERNEL_SLOTS) : 1;
    localparam int unsigned CNT_MAX = (FM_INIT_WORDS > KERNEL_SIZE) ? FM_INIT_WORDS : KERNEL_SIZE;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);

    localparam logic [1:0] OP_INIT_FM = 2'd0;
    localparam logic [1:0] OP_KERNEL  = 2'd1;
    localparam logic [1:0] OP_FM_WORD = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE, S_INIT_FM, S_KERN_W, S_KERN_B, S_FM_WORD, S_DONE
    } state_t;

    state_t                  state, state_d;
    logic [CW-1:0]           cnt, cnt_d;
    logic [1:0]              op_q, op_d;
    logic [ID_WIDTH-1:0]     id_q, id_d;
    logic [SW-1:0]           slot_q, slot_d;
    logic [W_ADDR_WIDTH-1:0] base_q, base_d;

    logic [ID_WIDTH-1:0]     last_id [4];
    logic [3:0]              last_vld;

    logic                     cmd_hs, src_hs, dup, slot_ok;
    logic                     cmd_ready_d, src_ready_d, busy_d;
    logic                     fm_we_d, w_we_d, b_we_d, done_valid_d;
    logic [FM_ADDR_WIDTH-1:0] fm_addr_d;
    logic [W_ADDR_WIDTH-1:0]  w_addr_d;
    logic [SW-1:0]            b_addr_d;
    logic [DATA_WIDTH-1:0]    fm_data_d, w_data_d, b_data_d;
    logic [1:0]               done_op_d;
    logic [ID_WIDTH-1:0]      done_id_d;

    // State and per-command context register
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            op_q   <= '0;
            id_q   <= '0;
            slot_q <= '0;
            base_q <= '0;
        end else begin
            state  <= state_d;
            cnt    <= cnt_d;
            op_q   <= op_d;
            id_q   <= id_d;
            slot_q <= slot_d;
            base_q <= base_d;
        end
    end

    // Next state and next values of every registered output
    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        op_d      = op_q;
        id_d      = id_q;
        slot_d    = slot_q;
        base_d    = base_q;
        fm_we_d   = 1'b0;
        fm_addr_d = bus.fm_addr;
        fm_data_d = bus.fm_data;
        w_we_d    = 1'b0;
        w_addr_d  = bus.w_addr;
        w_data_d  = bus.w_data;
        b_we_d    = 1'b0;
        b_addr_d  = bus.b_addr;
        b_data_d  = bus.b_data;

        cmd_hs  = bus.cmd_valid && bus.cmd_ready;
        src_hs  = bus.src_valid && bus.src_ready;
        dup     = last_vld[bus.cmd_op] && (last_id[bus.cmd_op] == bus.cmd_id);
        slot_ok = 32'(bus.cmd_slot) < KERNEL_SLOTS;

        case (state)
            S_IDLE: begin
                if (cmd_hs) begin
                    op_d   = bus.cmd_op;
                    id_d   = bus.cmd_id;
                    slot_d = bus.cmd_slot;
                    base_d = W_ADDR_WIDTH'(bus.cmd_slot) * W_ADDR_WIDTH'(KERNEL_SIZE);
                    cnt_d  = '0;
                    if (dup) begin
                        state_d = S_DONE;
                    end else begin
                        case (bus.cmd_op)
                            OP_INIT_FM: state_d = S_INIT_FM;
                            OP_KERNEL:  state_d = slot_ok ? S_KERN_W : S_DONE;
                            OP_FM_WORD: begin
                                state_d   = S_FM_WORD;
                                fm_we_d   = 1'b1;
                                fm_addr_d = bus.cmd_addr;
                                fm_data_d = bus.cmd_data;
                            end
                            default:    state_d = S_DONE;
                        endcase
                    end
                end
            end
            // Waits out the final write strobe so DONE lands one cycle after it
            S_INIT_FM: begin
                if (cnt == CW'(FM_INIT_WORDS)) begin
                    state_d = S_DONE;
                end else if (src_hs) begin
                    fm_we_d   = 1'b1;
                    fm_addr_d = FM_ADDR_WIDTH'(cnt);
                    fm_data_d = bus.src_data;
                    cnt_d     = cnt + CW'(1);
                end
            end
            S_KERN_W: begin
                if (src_hs) begin
                    w_we_d   = 1'b1;
                    w_addr_d = base_q + W_ADDR_WIDTH'(cnt);
                    w_data_d = bus.src_data;
                    if (cnt == CW'(KERNEL_SIZE - 1)) begin
                        state_d = S_KERN_B;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt + CW'(1);
                    end
                end
            end
            S_KERN_B: begin
                if (cnt != '0) begin
                    state_d = S_DONE;
                end else if (src_hs) begin
                    b_we_d   = 1'b1;
                    b_addr_d = slot_q;
                    b_data_d = bus.src_data;
                    cnt_d    = CW'(1);
                end
            end
            S_FM_WORD: state_d = S_DONE;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase

        cmd_ready_d  = (state_d == S_IDLE);
        busy_d       = (state_d != S_IDLE);
        src_ready_d  = ((state_d == S_INIT_FM) && (cnt_d != CW'(FM_INIT_WORDS))) ||
                       (state_d == S_KERN_W) ||
                       ((state_d == S_KERN_B) && (cnt_d == '0));
        done_valid_d = (state_d == S_DONE);
        done_op_d    = done_valid_d ? op_d : bus.done_op;
        done_id_d    = done_valid_d ? id_d : bus.done_id;
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.cmd_ready  <= 1'b0;
            bus.src_ready  <= 1'b0;
            bus.fm_we      <= 1'b0;
            bus.fm_addr    <= '0;
            bus.fm_data    <= '0;
            bus.w_we       <= 1'b0;
            bus.w_addr     <= '0;
            bus.w_data     <= '0;
            bus.b_we       <= 1'b0;
            bus.b_addr     <= '0;
            bus.b_data     <= '0;
            bus.done_valid <= 1'b0;
            bus.done_op    <= '0;
            bus.done_id    <= '0;
            bus.busy       <= 1'b0;
        end else begin
            bus.cmd_ready  <= cmd_ready_d;
            bus.src_ready  <= src_ready_d;
            bus.fm_we      <= fm_we_d;
            bus.fm_addr    <= fm_addr_d;
            bus.fm_data    <= fm_data_d;
            bus.w_we       <= w_we_d;
            bus.w_addr     <= w_addr_d;
            bus.w_data     <= w_data_d;
            bus.b_we       <= b_we_d;
            bus.b_addr     <= b_addr_d;
            bus.b_data     <= b_data_d;
            bus.done_valid <= done_valid_d;
            bus.done_op    <= done_op_d;
            bus.done_id    <= done_id_d;
            bus.busy       <= busy_d;
        end
    end

    // Last completed ID per op, recorded as the completion pulse is issued
    always_ff @(posedge clk) begin
        if (rst) begin
            last_vld <= '0;
            for (int i = 0; i < 4; i++) last_id[i] <= '0;
        end else if (state_d == S_DONE) begin
            last_vld[op_d] <= 1'b1;
            last_id[op_d]  <= id_d;
        end
    end
endmodule

// File: tb/tb_kernel_fm_load_controller.sv
// Directed bench for kernel_fm_load_controller: write logs collected at negedge are compared
// against hand-computed addresses, data and cycle offsets from each command's accept cycle.
module tb_kernel_fm_load_controller;
    localparam int unsigned DW = 16, FAW = 19, WAW = 13, KS = 3, KSZ = 4, FMW = 6, IDW = 4, SW = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   both_hi = 0;

    typedef struct { int cyc; int addr; int data; } wr_t;
    typedef struct { int cyc; int op; int id; } dn_t;
    wr_t fm_log[$];
    wr_t w_log[$];
    wr_t b_log[$];
    dn_t done_log[$];

    kernel_fm_load_if #(.DATA_WIDTH(DW), .FM_ADDR_WIDTH(FAW), .W_ADDR_WIDTH(WAW),
                        .ID_WIDTH(IDW), .SW(SW)) bus ();

    kernel_fm_load_controller #(
        .DATA_WIDTH(DW), .FM_ADDR_WIDTH(FAW), .W_ADDR_WIDTH(WAW), .KERNEL_SLOTS(KS),
        .KERNEL_SIZE(KSZ), .FM_INIT_WORDS(FMW), .ID_WIDTH(IDW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.fm_we) fm_log.push_back('{cyc, 32'(bus.fm_addr), 32'(bus.fm_data)});
        if (bus.w_we)  w_log.push_back('{cyc, 32'(bus.w_addr), 32'(bus.w_data)});
        if (bus.b_we)  b_log.push_back('{cyc, 32'(bus.b_addr), 32'(bus.b_data)});
        if (bus.done_valid) done_log.push_back('{cyc, 32'(bus.done_op), 32'(bus.done_id)});
        if (bus.fm_we && bus.w_we) both_hi++;
    end

    function automatic logic [94:0] all_outs();
        return {bus.cmd_ready, bus.src_ready, bus.fm_we, bus.fm_addr, bus.fm_data,
                bus.w_we, bus.w_addr, bus.w_data, bus.b_we, bus.b_addr, bus.b_data,
                bus.done_valid, bus.done_op, bus.done_id, bus.busy};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        fm_log.delete();
        w_log.delete();
        b_log.delete();
        done_log.delete();
    endtask

    task automatic issue(input logic [1:0] op, input logic [SW-1:0] slot, input logic [IDW-1:0] id,
                         input logic [FAW-1:0] addr, input logic [DW-1:0] data, output int acc);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_slot  = slot;
        bus.cmd_id    = id;
        bus.cmd_addr  = addr;
        bus.cmd_data  = data;
        acc = -1;
        for (int k = 0; k < 20; k++) begin
            if (bus.cmd_ready) begin
                acc = cyc;
                break;
            end
            tick();
        end
        if (acc < 0) begin
            n_vec++;
            n_err++;
            $display("FAIL cmd_accept: cmd_ready low for 20 cycles, required high");
        end
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic feed(input int n, input logic [DW-1:0] base, input int gap_at, input int gap_len);
        int k;
        for (int i = 0; i < n; i++) begin
            if (i == gap_at) begin
                bus.src_valid = 1'b0;
                repeat (gap_len) tick();
            end
            bus.src_valid = 1'b1;
            bus.src_data  = base + DW'(i);
            k = 0;
            while (!bus.src_ready && k < 20) begin
                tick();
                k++;
            end
            if (k == 20) begin
                n_vec++;
                n_err++;
                $display("FAIL src_ready_timeout: word %0d not accepted in 20 cycles", i);
                bus.src_valid = 1'b0;
                return;
            end
            tick();
        end
        bus.src_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_vec++;
        if (all_outs() !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h, required 0", all_outs());
        end
        rst = 1'b0;
        tick();
        n_vec++;
        if ({bus.cmd_ready, bus.busy, bus.src_ready} !== 3'b100) begin
            n_err++;
            $display("FAIL reset_release: ready/busy/src_ready got %b, required 100",
                     {bus.cmd_ready, bus.busy, bus.src_ready});
        end
    endtask

    task automatic test_init_fm();
        int acc;
        clear_logs();
        issue(2'd0, '0, 4'd1, '0, '0, acc);
        feed(6, 16'h0010, -1, 0);
        repeat (3) tick();
        n_vec++;
        if (fm_log.size() != 6) begin
            n_err++;
            $display("FAIL init_fm_count: got %0d writes, required 6", fm_log.size());
        end
        for (int i = 0; i < 6 && i < fm_log.size(); i++) begin
            n_vec++;
            if (fm_log[i].cyc !== acc + 2 + i || fm_log[i].addr !== i || fm_log[i].data !== 16 + i) begin
                n_err++;
                $display("FAIL init_fm_word%0d: got cyc+%0d addr %0d data %h, required cyc+%0d addr %0d data %h",
                         i, fm_log[i].cyc - acc, fm_log[i].addr, fm_log[i].data, 2 + i, i, 16 + i);
            end
        end
        n_vec++;
        if (w_log.size() + b_log.size() != 0) begin
            n_err++;
            $display("FAIL init_fm_stray: got %0d weight/bias writes, required 0", w_log.size() + b_log.size());
        end
        n_vec++;
        if (done_log.size() != 1) begin
            n_err++;
            $display("FAIL init_fm_done_count: got %0d, required 1", done_log.size());
        end else if (done_log[0].cyc !== acc + 8 || done_log[0].op !== 0 || done_log[0].id !== 1) begin
            n_err++;
            $display("FAIL init_fm_done: got cyc+%0d op %0d id %0d, required cyc+8 op 0 id 1",
                     done_log[0].cyc - acc, done_log[0].op, done_log[0].id);
        end
    endtask

    task automatic test_kernel_stall();
        int acc;
        int ecyc[4] = '{2, 3, 6, 7};
        clear_logs();
        issue(2'd1, 2'd2, 4'd3, '0, '0, acc);
        feed(5, 16'h00A0, 2, 2);
        repeat (3) tick();
        n_vec++;
        if (w_log.size() != 4) begin
            n_err++;
            $display("FAIL kstall_w_count: got %0d, required 4", w_log.size());
        end
        for (int i = 0; i < 4 && i < w_log.size(); i++) begin
            n_vec++;
            if (w_log[i].cyc !== acc + ecyc[i] || w_log[i].addr !== 8 + i || w_log[i].data !== 'hA0 + i) begin
                n_err++;
                $display("FAIL kstall_w%0d: got cyc+%0d addr %0d data %h, required cyc+%0d addr %0d data %h",
                         i, w_log[i].cyc - acc, w_log[i].addr, w_log[i].data, ecyc[i], 8 + i, 'hA0 + i);
            end
        end
        n_vec++;
        if (b_log.size() != 1) begin
            n_err++;
            $display("FAIL kstall_b_count: got %0d, required 1", b_log.size());
        end else if (b_log[0].cyc !== acc + 8 || b_log[0].addr !== 2 || b_log[0].data !== 'hA4) begin
            n_err++;
            $display("FAIL kstall_b: got cyc+%0d addr %0d data %h, required cyc+8 addr 2 data a4",
                     b_log[0].cyc - acc, b_log[0].addr, b_log[0].data);
        end
        n_vec++;
        if (done_log.size() != 1) begin
            n_err++;
            $display("FAIL kstall_done_count: got %0d, required 1", done_log.size());
        end else if (done_log[0].cyc !== acc + 9 || done_log[0].op !== 1 || done_log[0].id !== 3) begin
            n_err++;
            $display("FAIL kstall_done: got cyc+%0d op %0d id %0d, required cyc+9 op 1 id 3",
                     done_log[0].cyc - acc, done_log[0].op, done_log[0].id);
        end
    endtask

    task automatic test_duplicate();
        int acc;
        int src_hi = 0;
        clear_logs();
        bus.src_valid = 1'b1;
        bus.src_data  = 16'h0055;
        issue(2'd1, 2'd2, 4'd3, '0, '0, acc);
        for (int i = 0; i < 3; i++) begin
            if (bus.src_ready) src_hi++;
            tick();
        end
        bus.src_valid = 1'b0;
        n_vec++;
        if (src_hi != 0 || w_log.size() + b_log.size() != 0) begin
            n_err++;
            $display("FAIL dup_no_stream: got %0d src_ready cycles and %0d writes, required 0 and 0",
                     src_hi, w_log.size() + b_log.size());
        end
        n_vec++;
        if (done_log.size() != 1) begin
            n_err++;
            $display("FAIL dup_done_count: got %0d, required 1", done_log.size());
        end else if (done_log[0].cyc !== acc + 1 || done_log[0].op !== 1 || done_log[0].id !== 3) begin
            n_err++;
            $display("FAIL dup_done: got cyc+%0d op %0d id %0d, required cyc+1 op 1 id 3",
                     done_log[0].cyc - acc, done_log[0].op, done_log[0].id);
        end
        // Fresh ID into slot 0, back-to-back stream
        clear_logs();
        issue(2'd1, 2'd0, 4'd4, '0, '0, acc);
        feed(5, 16'h00B0, -1, 0);
        repeat (3) tick();
        n_vec++;
        if (w_log.size() != 4) begin
            n_err++;
            $display("FAIL slot0_w_count: got %0d, required 4", w_log.size());
        end
        for (int i = 0; i < 4 && i < w_log.size(); i++) begin
            n_vec++;
            if (w_log[i].cyc !== acc + 2 + i || w_log[i].addr !== i || w_log[i].data !== 'hB0 + i) begin
                n_err++;
                $display("FAIL slot0_w%0d: got cyc+%0d addr %0d data %h, required cyc+%0d addr %0d data %h",
                         i, w_log[i].cyc - acc, w_log[i].addr, w_log[i].data, 2 + i, i, 'hB0 + i);
            end
        end
        n_vec++;
        if (b_log.size() != 1 || done_log.size() != 1) begin
            n_err++;
            $display("FAIL slot0_counts: got %0d bias %0d done, required 1 and 1", b_log.size(), done_log.size());
        end else if (b_log[0].addr !== 0 || b_log[0].data !== 'hB4 || b_log[0].cyc !== acc + 6 ||
                     done_log[0].cyc !== acc + 7 || done_log[0].id !== 4) begin
            n_err++;
            $display("FAIL slot0_bias_done: got b cyc+%0d addr %0d data %h done cyc+%0d id %0d, required 6 0 b4 7 4",
                     b_log[0].cyc - acc, b_log[0].addr, b_log[0].data, done_log[0].cyc - acc, done_log[0].id);
        end
    endtask

    task automatic test_fm_word();
        int acc;
        logic [2:0] rdy;
        clear_logs();
        issue(2'd2, '0, 4'd5, 19'h7FFFF, 16'hBEEF, acc);
        rdy[0] = bus.cmd_ready;
        tick();
        rdy[1] = bus.cmd_ready;
        tick();
        rdy[2] = bus.cmd_ready;
        tick();
        n_vec++;
        if (rdy !== 3'b100) begin
            n_err++;
            $display("FAIL fm_word_ready: cmd_ready at +3/+2/+1 got %b, required 100", rdy);
        end
        n_vec++;
        if (fm_log.size() != 1) begin
            n_err++;
            $display("FAIL fm_word_count: got %0d, required 1", fm_log.size());
        end else if (fm_log[0].cyc !== acc + 1 || fm_log[0].addr !== 'h7FFFF || fm_log[0].data !== 'hBEEF) begin
            n_err++;
            $display("FAIL fm_word_write: got cyc+%0d addr %h data %h, required cyc+1 addr 7ffff data beef",
                     fm_log[0].cyc - acc, fm_log[0].addr, fm_log[0].data);
        end
        n_vec++;
        if (done_log.size() != 1) begin
            n_err++;
            $display("FAIL fm_word_done_count: got %0d, required 1", done_log.size());
        end else if (done_log[0].cyc !== acc + 2 || done_log[0].op !== 2 || done_log[0].id !== 5) begin
            n_err++;
            $display("FAIL fm_word_done: got cyc+%0d op %0d id %0d, required cyc+2 op 2 id 5",
                     done_log[0].cyc - acc, done_log[0].op, done_log[0].id);
        end
        n_vec++;
        if ({bus.done_valid, bus.done_op, bus.done_id} !== {1'b0, 2'd2, 4'd5}) begin
            n_err++;
            $display("FAIL done_hold: got valid %b op %0d id %0d, required 0 2 5",
                     bus.done_valid, bus.done_op, bus.done_id);
        end
    endtask

    task automatic test_reset_abort();
        int acc;
        clear_logs();
        issue(2'd1, 2'd1, 4'd9, '0, '0, acc);
        feed(2, 16'h00C0, -1, 0);
        rst = 1'b1;
        tick();
        n_vec++;
        if (all_outs() !== '0) begin
            n_err++;
            $display("FAIL abort_outputs: got %h, required 0", all_outs());
        end
        rst = 1'b0;
        repeat (4) tick();
        n_vec++;
        if (done_log.size() != 0 || w_log.size() != 2 || bus.cmd_ready !== 1'b1) begin
            n_err++;
            $display("FAIL abort_state: got %0d done %0d w writes ready %b, required 0 2 1",
                     done_log.size(), w_log.size(), bus.cmd_ready);
        end
        // ID history was cleared, so id 3 runs in full
        clear_logs();
        issue(2'd1, 2'd1, 4'd3, '0, '0, acc);
        feed(5, 16'h00D0, -1, 0);
        repeat (3) tick();
        n_vec++;
        if (w_log.size() != 4 || b_log.size() != 1 || done_log.size() != 1) begin
            n_err++;
            $display("FAIL rerun_counts: got %0d w %0d b %0d done, required 4 1 1",
                     w_log.size(), b_log.size(), done_log.size());
        end else if (w_log[0].addr !== 4 || w_log[3].addr !== 7 || b_log[0].addr !== 1 ||
                     b_log[0].data !== 'hD4 || done_log[0].cyc !== b_log[0].cyc + 1 || done_log[0].id !== 3) begin
            n_err++;
            $display("FAIL rerun_values: got w %0d..%0d b %0d/%h done gap %0d id %0d, required 4..7 1/d4 1 3",
                     w_log[0].addr, w_log[3].addr, b_log[0].addr, b_log[0].data,
                     done_log[0].cyc - b_log[0].cyc, done_log[0].id);
        end
    endtask

    task automatic test_out_of_range();
        int acc;
        clear_logs();
        issue(2'd1, 2'd3, 4'd6, '0, '0, acc);
        repeat (3) tick();
        n_vec++;
        if (fm_log.size() + w_log.size() + b_log.size() != 0) begin
            n_err++;
            $display("FAIL oor_writes: got %0d, required 0", fm_log.size() + w_log.size() + b_log.size());
        end
        n_vec++;
        if (done_log.size() != 1) begin
            n_err++;
            $display("FAIL oor_done_count: got %0d, required 1", done_log.size());
        end else if (done_log[0].cyc !== acc + 1 || done_log[0].op !== 1 || done_log[0].id !== 6) begin
            n_err++;
            $display("FAIL oor_done: got cyc+%0d op %0d id %0d, required cyc+1 op 1 id 6",
                     done_log[0].cyc - acc, done_log[0].op, done_log[0].id);
        end
        clear_logs();
        issue(2'd3, '0, 4'd2, '0, '0, acc);
        repeat (3) tick();
        n_vec++;
        if (done_log.size() != 1 || fm_log.size() + w_log.size() + b_log.size() != 0) begin
            n_err++;
            $display("FAIL reserved_counts: got %0d done %0d writes, required 1 0",
                     done_log.size(), fm_log.size() + w_log.size() + b_log.size());
        end else if (done_log[0].cyc !== acc + 1 || done_log[0].op !== 3 || done_log[0].id !== 2) begin
            n_err++;
            $display("FAIL reserved_done: got cyc+%0d op %0d id %0d, required cyc+1 op 3 id 2",
                     done_log[0].cyc - acc, done_log[0].op, done_log[0].id);
        end
    endtask

    task automatic test_exclusive();
        n_vec++;
        if (both_hi != 0) begin
            n_err++;
            $display("FAIL port_exclusive: fm_we and w_we both high in %0d cycles, required 0", both_hi);
        end
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = '0;
        bus.cmd_slot  = '0;
        bus.cmd_id    = '0;
        bus.cmd_addr  = '0;
        bus.cmd_data  = '0;
        bus.src_valid = 1'b0;
        bus.src_data  = '0;
        test_reset();
        test_init_fm();
        test_kernel_stall();
        test_duplicate();
        test_fm_word();
        test_reset_abort();
        test_out_of_range();
        test_exclusive();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded 200000 time units");
        $fatal(1);
    end
endmodule
